// File: rtl/xoodoo_rdi_pkg.sv
// Shared constants, state encoding and seeding helper for the Xoodoo randomness generator.
package xoodoo_rdi_pkg;

    localparam int unsigned LANES  = 12;
    localparam int unsigned LANE_W = 64;
    localparam logic [LANE_W-1:0] K = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [1:0] {
        StUnseeded,
        StWarmup,
        StReady
    } rdi_state_e;

    // A zero xorshift state is a fixed point, so a seed that cancels a lane constant loads K.
    function automatic logic [LANE_W-1:0] seed_lane(input logic [LANE_W-1:0] seed,
                                                    input int unsigned idx);
        logic [LANE_W-1:0] mult;
        logic [LANE_W-1:0] val;
        mult = K * LANE_W'(idx + 1);
        val  = seed ^ mult;
        return (val == '0) ? K : val;
    endfunction

endpackage

// File: rtl/xorshift64_lane.sv
// One combinational xorshift64 step (13, 7, 17), 64-bit wrap.
module xorshift64_lane
    import xoodoo_rdi_pkg::*;
(
    input  logic [LANE_W-1:0] x_i,
    output logic [LANE_W-1:0] y_o
);

    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;

    always_comb begin
        a   = x_i ^ (x_i << 13);
        b   = a ^ (a >> 7);
        y_o = b ^ (b << 17);
    end

endmodule

// File: rtl/xoodoo_rdi_gen.sv
// Twelve-lane xorshift64 randomness source feeding the threshold Xoodoo core over rdi_valid/ready.
module xoodoo_rdi_gen
    import xoodoo_rdi_pkg::*;
#(
    parameter int unsigned WARMUP = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [63:0]              seed_i,
    input  logic                     seed_valid_i,
    output logic                     seed_ready_o,
    output logic                     rdi_valid_o,
    input  logic                     rdi_ready_i,
    output logic [LANES/2*LANE_W-1:0] rs0_o,
    output logic [LANES/2*LANE_W-1:0] rs1_o,
    output logic [31:0]              words_o
);

    localparam logic [7:0] WarmLast = 8'(WARMUP - 1);

    rdi_state_e        state_q;
    logic              valid_q;
    logic [7:0]        warm_cnt_q;
    logic [31:0]       words_q;
    logic [LANE_W-1:0] lane_q   [LANES];
    logic [LANE_W-1:0] step_val [LANES];
    logic [LANE_W-1:0] seed_val [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        xorshift64_lane u_lane (
            .x_i (lane_q[g]),
            .y_o (step_val[g])
        );
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            seed_val[i] = seed_lane(seed_i, i);
        end
    end

    // Reseed wins over any step, including a READY transfer in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StUnseeded;
            valid_q    <= 1'b0;
            warm_cnt_q <= '0;
            words_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else if (seed_valid_i) begin
            state_q    <= StWarmup;
            valid_q    <= 1'b0;
            warm_cnt_q <= '0;
            words_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= seed_val[i];
            end
        end else begin
            unique case (state_q)
                StUnseeded: begin
                    valid_q <= 1'b0;
                end
                StWarmup: begin
                    for (int i = 0; i < LANES; i++) begin
                        lane_q[i] <= step_val[i];
                    end
                    warm_cnt_q <= warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WarmLast) begin
                        state_q <= StReady;
                        valid_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (rdi_ready_i) begin
                        for (int i = 0; i < LANES; i++) begin
                            lane_q[i] <= step_val[i];
                        end
                        if (words_q != '1) begin
                            words_q <= words_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StUnseeded;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rs0_o = '0;
        rs1_o = '0;
        for (int i = 0; i < LANES / 2; i++) begin
            rs0_o[i*LANE_W +: LANE_W] = lane_q[i];
            rs1_o[i*LANE_W +: LANE_W] = lane_q[i + LANES/2];
        end
    end

    assign seed_ready_o = ~rst_i;
    assign rdi_valid_o  = valid_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_xoodoo_rdi_gen.sv
// Scoreboard bench for xoodoo_rdi_gen: stimulus queues expected words, a negedge monitor checks them.
module tb_xoodoo_rdi_gen;

    localparam int unsigned WARM = 16;
    localparam logic [63:0] KC   = 64'h9E37_79B9_7F4A_7C15;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [63:0]  seed_i;
    logic         seed_valid_i;
    logic         seed_ready_o;
    logic         rdi_valid_o;
    logic         rdi_ready_i;
    logic [383:0] rs0_o;
    logic [383:0] rs1_o;
    logic [31:0]  words_o;

    xoodoo_rdi_gen #(.WARMUP(WARM)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_i       (seed_i),
        .seed_valid_i (seed_valid_i),
        .seed_ready_o (seed_ready_o),
        .rdi_valid_o  (rdi_valid_o),
        .rdi_ready_i  (rdi_ready_i),
        .rs0_o        (rs0_o),
        .rs1_o        (rs1_o),
        .words_o      (words_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [383:0] rs0;
        logic [383:0] rs1;
        logic [31:0]  words;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_lane [12];
    logic [31:0] m_words;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    task automatic m_seed(input logic [63:0] s);
        for (int i = 0; i < 12; i++) begin
            m_lane[i] = s ^ (KC * 64'(i + 1));
            if (m_lane[i] == 64'h0) m_lane[i] = KC;
        end
        m_words = 32'h0;
    endtask

    task automatic m_step();
        for (int i = 0; i < 12; i++) m_lane[i] = xs(m_lane[i]);
    endtask

    function automatic logic [383:0] pack(input int base);
        logic [383:0] r;
        for (int i = 0; i < 6; i++) r[i*64 +: 64] = m_lane[base + i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Seed accepted at the next edge; ready is dropped right after so no transfer follows.
    task automatic do_seed(input logic [63:0] s);
        seed_i       = s;
        seed_valid_i = 1'b1;
        tick();
        seed_valid_i = 1'b0;
        rdi_ready_i  = 1'b0;
        m_seed(s);
    endtask

    task automatic warmup(input logic rq);
        for (int k = 1; k <= int'(WARM); k++) begin
            rdi_ready_i = rq;
            tick();
            rdi_ready_i = 1'b0;
            m_step();
            check64("valid_timing", 64'(rdi_valid_o), 64'(k == int'(WARM)));
        end
        check("warm_rs0", rs0_o, pack(0));
        check("warm_rs1", rs1_o, pack(6));
    endtask

    task automatic xfer_cycle(input logic r);
        rdi_ready_i = r;
        if (r) exp_q.push_back('{rs0: pack(0), rs1: pack(6), words: m_words});
        tick();
        if (r) begin
            m_step();
            if (m_words != 32'hFFFF_FFFF) m_words++;
        end
    endtask

    // Monitor: pops one expected word per transfer, and checks data holds while ready is low.
    logic [383:0] prev0;
    logic [383:0] prev1;
    logic         prev_hold = 1'b0;
    logic         zero_lane;
    exp_t         e;

    always @(negedge clk_i) begin
        if (rdi_valid_o === 1'b1) begin
            if (prev_hold) begin
                check("hold_rs0", rs0_o, prev0);
                check("hold_rs1", rs1_o, prev1);
            end
            if (rdi_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got rs0 %h want none", rs0_o[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_rs0", rs0_o, e.rs0);
                    check("xfer_rs1", rs1_o, e.rs1);
                    check64("xfer_words", 64'(words_o), 64'(e.words));
                end
                zero_lane = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    if (rs0_o[i*64 +: 64] == 64'h0 || rs1_o[i*64 +: 64] == 64'h0) zero_lane = 1'b1;
                end
                check64("lane_nonzero", 64'(zero_lane), 64'h0);
            end
            prev_hold = !rdi_ready_i;
            prev0     = rs0_o;
            prev1     = rs1_o;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        rst_i        = 1'b1;
        seed_i       = 64'h0;
        seed_valid_i = 1'b0;
        rdi_ready_i  = 1'b0;
        #2;
        check64("rst_seed_ready", 64'(seed_ready_o), 64'h0);
        check64("rst_valid", 64'(rdi_valid_o), 64'h0);
        check64("rst_words", 64'(words_o), 64'h0);
        check("rst_rs0", rs0_o, 384'h0);
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        check64("seed_ready_up", 64'(seed_ready_o), 64'h1);

        // Unseeded idle: ready has no effect.
        rdi_ready_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check64("idle", {61'h0, rdi_valid_o, |rs0_o, |rs1_o} | 64'(words_o), 64'h0);
        end
        rdi_ready_i = 1'b0;

        // Seed 0: L0 = K, L1 = 2K.
        do_seed(64'h0);
        check64("seed0_l0", rs0_o[63:0], KC);
        check64("seed0_l1", rs0_o[127:64], 64'h3C6E_F372_FE94_F82A);
        warmup(1'b1);

        // Ready pattern 1,0,0,1,1 consumes steps 16, 17, 18.
        xfer_cycle(1'b1);
        xfer_cycle(1'b0);
        xfer_cycle(1'b0);
        xfer_cycle(1'b1);
        xfer_cycle(1'b1);
        rdi_ready_i = 1'b0;
        check64("pattern_words", 64'(words_o), 64'd3);
        check("pattern_step19", rs0_o, pack(0));

        // Seed K: L0 cancels to zero and is forced to K; L1 = K ^ 2K.
        do_seed(KC);
        check64("seedk_l0", rs0_o[63:0], KC);
        check64("seedk_l1", rs0_o[127:64], 64'hA259_8ACB_81DE_843F);
        warmup(1'b0);
        for (int c = 0; c < 10000; c++) xfer_cycle(1'b1);
        rdi_ready_i = 1'b0;
        check64("long_words", 64'(words_o), 64'd10000);

        // Reseed on a transfer cycle: the old word still transfers.
        rdi_ready_i = 1'b1;
        exp_q.push_back('{rs0: pack(0), rs1: pack(6), words: m_words});
        do_seed(64'h1234);
        check64("reseed_valid", 64'(rdi_valid_o), 64'h0);
        check64("reseed_words", 64'(words_o), 64'h0);
        warmup(1'b0);
        for (int c = 0; c < 5; c++) xfer_cycle(1'b1);
        rdi_ready_i = 1'b0;
        check64("reseed_words_end", 64'(words_o), 64'd5);

        // Asynchronous reset while READY.
        #1 rst_i = 1'b1;
        #1;
        check64("areset_ready_valid", 64'(rdi_valid_o), 64'h0);
        check("areset_ready_rs0", rs0_o, 384'h0);
        check64("areset_ready_words", 64'(words_o), 64'h0);
        tick();
        #2 rst_i = 1'b0;

        // Asynchronous reset mid-WARMUP, then stays unseeded.
        do_seed(64'h55);
        repeat (5) tick();
        #1 rst_i = 1'b1;
        #1;
        check64("areset_warm_valid", 64'(rdi_valid_o), 64'h0);
        check("areset_warm_rs0", rs0_o, 384'h0);
        check("areset_warm_rs1", rs1_o, 384'h0);
        check64("areset_warm_sready", 64'(seed_ready_o), 64'h0);
        tick();
        #2 rst_i = 1'b0;
        rdi_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check64("post_reset_idle", {62'h0, rdi_valid_o, |rs0_o}, 64'h0);
        end
        rdi_ready_i = 1'b0;
        tick();
        check64("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xoodoo_rdi_gen.md
# xoodoo_rdi_gen

Randomness source for the first-order threshold Xoodoo permutation core. It produces two 384-bit random shares per permutation round cycle on `rs0_o` and `rs1_o` and acts as the transmitter side of the `rdi_valid`/`rdi_ready` interface the permutation consumes. The block is seeded through a simple valid/ready port, discards a fixed warm-up sequence, and then advances one step per accepted transfer. It sits beside the permutation in CryptoCore_SCA.

## Interface

Parameters:
- `WARMUP`, 16: number of discarded state steps after each seed load, in the range 1–255.

Ports:
- `clk_i`  in  1  the single clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `seed_i`  in  64  seed value.
- `seed_valid_i`  in  1  seed offered.
- `seed_ready_o`  out  1  seed accepted; constant 1 when not in reset.
- `rdi_valid_o`  out  1  `rs0_o`/`rs1_o` hold fresh randomness.
- `rdi_ready_i`  in  1  consumer uses the current word this cycle; driven by the permutation's start-or-running signal.
- `rs0_o`  out  384  share-0 randomness.
- `rs1_o`  out  384  share-1 randomness.
- `words_o`  out  32  count of transfers since the last seed; saturates at `32'hFFFF_FFFF`.

## Operation

Datapath:
- 12 independent xorshift64 lanes, L0 to L11.
- One lane step is `x ^= x<<13; x ^= x>>7; x ^= x<<17`, all 64-bit wrap.
- Seed load: Li = `seed_i ^ (K*(i+1) mod 2^64)` with K = `64'h9E37_79B9_7F4A_7C15`.
- If a seeded lane value is 0, that lane loads K instead. This keeps every lane nonzero forever.
- Output mapping: `rs0_o = {L5,L4,L3,L2,L1,L0}` and `rs1_o = {L11,…,L6}`. L0 occupies bits [63:0].

FSM states:
- **UNSEEDED**: `rdi_valid_o`=0, lanes hold.
  - Goes to WARMUP on `seed_valid_i`.
- **WARMUP**: all lanes step every cycle and `warm_cnt` increments.
  - Goes to READY when `warm_cnt == WARMUP-1` and a step occurs.
- **READY**: `rdi_valid_o`=1.
  - Lanes step at the clock edge only when `rdi_ready_i` is high. Otherwise outputs are held stable.
  - `words_o` increments once per transfer.

Rules:
- A transfer is a cycle with `rdi_valid_o & rdi_ready_i`.
- Reseed: `seed_valid_i` in any state has priority over stepping. Lanes reload, `warm_cnt`=0, `words_o`=0, and the next state is WARMUP.
- `rdi_valid_o` is a registered function of the FSM state only. It never depends combinationally on `rdi_ready_i` or `seed_valid_i`.
- `rdi_ready_i` has no effect outside READY.

## Timing

- Reset values:
  - state = UNSEEDED.
  - all lanes = 0, `rdi_valid_o`=0, `rs0_o`=`rs1_o`=0, `words_o`=0, `warm_cnt`=0.
  - `seed_ready_o`=0 while `rst_i` is high and 1 afterwards.
- Seed accepted at edge t: lanes hold their seeded values after t.
- `rdi_valid_o` rises after edge t+WARMUP. The outputs then show the lanes stepped WARMUP times.
- During READY, data is valid in the cycle it is presented. The consumer samples it combinationally in the same cycle. The next word appears one cycle after each transfer, with no bubble.
- Sustained `rdi_ready_i`=1 gives one new 768-bit word per clock.
- Reset mid-WARMUP or mid-READY returns to UNSEEDED asynchronously, and `rdi_valid_o` drops immediately.
- Reseed while `rdi_ready_i`=1 in READY: the current cycle still counts as the consumer's transfer of the old word. `rdi_valid_o` falls at the next edge.
- `words_o` stops at all-ones and does not wrap.

## Structure

- Package `xoodoo_rdi_pkg` holds:
  - the K constant;
  - `LANES`=12 and `LANE_W`=64;
  - the FSM state enum {UNSEEDED, WARMUP, READY}.
- Sub-module `xorshift64_lane`: combinational single-step function from 64 bits to 64 bits, instantiated 12 times. Seeding, the FSM and the counters live in the top level.

## Test plan

1. Reset, then idle for 50 cycles with `rdi_ready_i`=1 → `rdi_valid_o`=0, `rs0_o`=`rs1_o`=0, `words_o`=0 throughout.
2. Seed `64'h0` at edge t → L0 seeded to K. `rdi_valid_o` rises exactly at t+16. First `rs0_o[63:0]` equals the model's K after 16 steps, and all 12 lanes match the C model.
3. Seed `64'h9E37_79B9_7F4A_7C15` → L0 would be 0 and is forced to K. Outputs match the model, and no lane is ever 0 over 10 000 transfers.
4. In READY, toggle `rdi_ready_i` in the pattern 1,0,0,1,1 → outputs stay stable while ready is low. `words_o` ends at 3, and the data sequence equals model steps 16, 17, 18, 19 with no skipped or repeated value.
5. Reseed with `64'h1234` during a READY transfer cycle → that transfer is counted, then `rdi_valid_o`=0 for 16 cycles. `words_o` resets to 0, and the new stream matches the model for seed `64'h1234`.
6. Assert `rst_i` asynchronously mid-WARMUP (between edges) → `rdi_valid_o` and all outputs go to 0 before the next edge, and the state remains UNSEEDED after release.
